// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: requester side of the signed ALU interface.
// Accepts commands over valid/ready, drives registered operands into the combinational ALU,
// samples result+flags SETTLE cycles later and queues tagged responses in a small FIFO.
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake; cmd_a_i, cmd_b_i, cmd_opt_i command fields
//   alu_a_o, alu_b_o, alu_opt_o  registered operands/opcode to the ALU
//   alu_result_i, alu_*_i      ALU result and flags
//   rsp_valid_o/rsp_ready_i    response handshake; rsp_result_o, rsp_flags_o, rsp_tag_o head entry
//   op_count_o                 completed operations (wraps)
module alu_cmd_sequencer #(
   parameter int WIDTH      = 4,
   parameter int SETTLE     = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_a_i,
   input  logic [WIDTH-1:0] cmd_b_i,
   input  logic [2:0]       cmd_opt_i,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [2:0]       alu_opt_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_less_i,
   input  logic             alu_equal_i,
   input  logic             alu_carry_i,
   input  logic             alu_overflow_i,
   input  logic             alu_zero_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_result_o,
   output logic [4:0]       rsp_flags_o,
   output logic [2:0]       rsp_tag_o,
   output logic [7:0]       op_count_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(SETTLE + 1);
   localparam int EW = WIDTH + 8;
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t           state_q;
   logic [SW-1:0]    settle_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [2:0]       alu_opt_q;
   logic [2:0]       tag_q;
   logic [7:0]       op_count_q;
   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d, remain;
   logic [EW-1:0]    rsp_q, push_data, head_d;
   logic             accept, push, pop;
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_opt_o   = alu_opt_q;
   assign op_count_o  = op_count_q;
   assign {rsp_tag_o, rsp_flags_o, rsp_result_o} = rsp_q;
   assign rsp_valid_o = cnt_q != '0;
   assign cmd_ready_o = state_q == S_IDLE && cnt_q != (AW+1)'(FIFO_DEPTH);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign push        = state_q == S_WAIT && settle_q == SW'(1);
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign push_data   = {tag_q, alu_zero_i, alu_overflow_i, alu_carry_i, alu_equal_i, alu_less_i, alu_result_i};
   // The head register is preloaded with whatever will sit at the FIFO head after this edge,
   // bypassing the memory when the pushed entry lands in an otherwise empty FIFO.
   // When the FIFO drains, the head register keeps the last popped entry.
   always_comb begin
      rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
      remain = cnt_q - (AW+1)'(pop);
      cnt_d  = remain + (AW+1)'(push);
      head_d = remain == '0 ? push_data : mem_q[rptr_d];
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         settle_q   <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_opt_q  <= '0;
         tag_q      <= '0;
         op_count_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         rsp_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               alu_a_q   <= cmd_a_i;
               alu_b_q   <= cmd_b_i;
               alu_opt_q <= cmd_opt_i;
               settle_q  <= SW'(SETTLE);
               state_q   <= S_WAIT;
            end
            S_WAIT: if (push) begin
               tag_q      <= tag_q + 1'b1;
               op_count_q <= op_count_q + 1'b1;
               state_q    <= S_IDLE;
            end else begin
               settle_q <= settle_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
         if (push) begin
            mem_q[wptr_q] <= push_data;
            wptr_q        <= wptr_q + 1'b1;
         end
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (cnt_d != '0) rsp_q <= head_d;
      end
   end
   // Acceptance requires a free slot and only one op is in flight, so a push can never find the FIFO full.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(push && !pop && cnt_q == (AW+1)'(FIFO_DEPTH)));
endmodule
